// File: rtl/vec_burst_write_master.sv
// rtl/vec_burst_write_master.sv - Avalon-MM burst write master draining a buffered producer stream to SDRAM
module vec_burst_write_master #(
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_BURST  = 8
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write,
    input  logic [2:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic [31:0] avm_address,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    output logic [7:0]  avm_burstcount,
    input  logic        avm_waitrequest
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT  = CW'(FIFO_DEPTH);
    localparam logic [31:0]   MAX_BURST_W = 32'(MAX_BURST);
    localparam logic [7:0]    MAX_BURST_B = 8'(MAX_BURST);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_BURST,
        S_DONE
    } state_t;

    state_t        state;

    logic [31:0]   len_reg;
    logic [31:0]   base_reg;
    logic [31:0]   words_written;
    logic [31:0]   rem_in;
    logic [31:0]   rem_out;
    logic [31:0]   cur_addr;
    logic          done;
    logic [7:0]    beat_cnt;

    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] fifo_count;

    logic          busy;
    logic          csr_wr;
    logic          start;
    logic          push;
    logic          pop;
    logic [7:0]    blen;

    assign busy           = (state == S_WAIT) || (state == S_BURST);
    assign csr_wr         = chipselect & write;
    assign start          = csr_wr && (address == 3'd0);
    // Never take more words than remain in the transfer, and never overrun the buffer.
    assign in_ready       = busy && (rem_in != 32'd0) && (fifo_count != FULL_COUNT);
    assign push           = in_valid & in_ready;
    // avm_write is only high in BURST, so this is exactly an accepted beat.
    assign pop            = avm_write & ~avm_waitrequest;
    assign blen           = (rem_out > MAX_BURST_W) ? MAX_BURST_B : rem_out[7:0];
    assign avm_byteenable = 4'b1111;
    // Head of the buffer; it only moves on an accepted beat, so it is stable while stalled.
    assign avm_writedata  = avm_write ? fifo_mem[rd_ptr] : 32'd0;

    // CSR read mux, zero unless a read is actually selected
    always_comb begin
        readdata = 32'd0;
        if (chipselect && read) begin
            case (address)
                3'd0:    readdata = {30'd0, done, busy};
                3'd1:    readdata = len_reg;
                3'd2:    readdata = base_reg;
                3'd3:    readdata = words_written;
                default: readdata = 32'd0;
            endcase
        end
    end

    // Buffer storage; contents need no reset because pointers define validity
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= in_data;
        end
    end

    // Buffer pointers and occupancy
    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Control FSM with CSR registers, transfer counters and registered bus outputs
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state          <= S_IDLE;
            len_reg        <= 32'd0;
            base_reg       <= 32'd0;
            words_written  <= 32'd0;
            rem_in         <= 32'd0;
            rem_out        <= 32'd0;
            cur_addr       <= 32'd0;
            done           <= 1'b0;
            beat_cnt       <= 8'd0;
            avm_write      <= 1'b0;
            avm_address    <= 32'd0;
            avm_burstcount <= 8'd0;
        end else begin
            if (push) begin
                rem_in <= rem_in - 32'd1;
            end
            if (csr_wr && !busy && (address == 3'd1)) begin
                len_reg <= writedata;
            end
            if (csr_wr && !busy && (address == 3'd2)) begin
                base_reg <= {writedata[31:2], 2'b00};
            end

            case (state)
                S_IDLE, S_DONE: begin
                    state <= S_IDLE;
                    if (start) begin
                        if (len_reg != 32'd0) begin
                            rem_in        <= len_reg;
                            rem_out       <= len_reg;
                            cur_addr      <= base_reg;
                            words_written <= 32'd0;
                            done          <= 1'b0;
                            state         <= S_WAIT;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end

                S_WAIT: begin
                    // Launch only once every beat of the burst is already buffered.
                    if (32'(fifo_count) >= 32'(blen)) begin
                        avm_address    <= cur_addr;
                        avm_burstcount <= blen;
                        beat_cnt       <= blen;
                        avm_write      <= 1'b1;
                        state          <= S_BURST;
                    end
                end

                S_BURST: begin
                    if (!avm_waitrequest) begin
                        beat_cnt      <= beat_cnt - 8'd1;
                        rem_out       <= rem_out - 32'd1;
                        words_written <= words_written + 32'd1;
                        if (beat_cnt == 8'd1) begin
                            avm_write <= 1'b0;
                            cur_addr  <= cur_addr + {22'd0, avm_burstcount, 2'b00};
                            if (rem_out == 32'd1) begin
                                done  <= 1'b1;
                                state <= S_DONE;
                            end else begin
                                state <= S_WAIT;
                            end
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_burst_write_master.sv
// tb/tb_vec_burst_write_master.sv - self-checking bench for vec_burst_write_master
module tb_vec_burst_write_master;

    localparam int MAXB = 8;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        chipselect = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [2:0]  address = 3'd0;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'd0;
    logic        in_ready;
    logic [31:0] avm_address;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic [7:0]  avm_burstcount;
    logic        avm_waitrequest = 1'b0;

    vec_burst_write_master dut (
        .clock          (clock),
        .resetn         (resetn),
        .chipselect     (chipselect),
        .read           (read),
        .write          (write),
        .address        (address),
        .writedata      (writedata),
        .readdata       (readdata),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .avm_address    (avm_address),
        .avm_write      (avm_write),
        .avm_writedata  (avm_writedata),
        .avm_byteenable (avm_byteenable),
        .avm_burstcount (avm_burstcount),
        .avm_waitrequest(avm_waitrequest)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  bc;
    } burst_t;

    typedef struct {
        int          n;
        logic [31:0] base;
        bit          stall;
        int          gap;
        logic [31:0] exp_ww;
        logic [31:0] exp_status;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_data_q[$];
    burst_t      burst_q[$];
    int          hs_cnt = 0;
    int          beat_cnt = 0;
    int          beats_left = 0;
    bit          mon_en = 1'b0;
    bit          prod_en = 1'b0;
    bit          stall_en = 1'b0;
    int          gap = 0;
    int          cool = 0;
    int          stall_left = 0;
    logic [31:0] word_val = 32'd0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = 32'd0;
    logic [31:0] cur_baddr = 32'd0;
    logic [7:0]  cur_bc = 8'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
        @(posedge clock);
        #3;
        chipselect = 1'b1;
        write      = 1'b1;
        address    = a;
        writedata  = d;
        @(posedge clock);
        #3;
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
        chipselect = 1'b1;
        read       = 1'b1;
        address    = a;
        #1;
        d          = readdata;
        chipselect = 1'b0;
        read       = 1'b0;
    endtask

    // Bus monitor: checks each beat against the scoreboard and the expected burst list
    task automatic monitor_step();
        burst_t eb;
        if (avm_write) begin
            if (beats_left == 0) begin
                if (burst_q.size() == 0) begin
                    chk("unexpected_burst_write", {31'd0, avm_write}, 32'd0);
                    cur_baddr  = avm_address;
                    cur_bc     = avm_burstcount;
                    beats_left = (avm_burstcount == 8'd0) ? 1 : int'(avm_burstcount);
                end else begin
                    eb = burst_q.pop_front();
                    chk("burst_address", avm_address, eb.addr);
                    chk("burst_count", 32'(avm_burstcount), 32'(eb.bc));
                    cur_baddr  = eb.addr;
                    cur_bc     = eb.bc;
                    beats_left = int'(eb.bc);
                end
                chk("burst_fully_buffered", 32'((hs_cnt - beat_cnt) >= int'(cur_bc)), 32'd1);
                chk("byteenable", 32'(avm_byteenable), 32'hf);
            end else begin
                chk("hold_address", avm_address, cur_baddr);
                chk("hold_burstcount", 32'(avm_burstcount), 32'(cur_bc));
                if (prev_stall) begin
                    chk("hold_writedata", avm_writedata, prev_data);
                end
            end
            if (!avm_waitrequest) begin
                if (exp_data_q.size() == 0) begin
                    chk("writedata_underrun", {31'd0, avm_write}, 32'd0);
                end else begin
                    chk("writedata", avm_writedata, exp_data_q.pop_front());
                end
                beats_left--;
                beat_cnt++;
            end
            prev_stall = avm_waitrequest;
            prev_data  = avm_writedata;
        end else begin
            if (beats_left != 0) begin
                chk("write_bubble", {31'd0, avm_write}, 32'd1);
            end
            prev_stall = 1'b0;
        end
    endtask

    // Agent: monitor + producer + slave stall generator, one process to keep shared counters race-free
    initial begin
        forever begin
            @(negedge clock);
            if (mon_en) begin
                monitor_step();
            end
            if (in_valid && in_ready) begin
                exp_data_q.push_back(in_data);
                hs_cnt++;
                word_val = word_val + 32'd1;
                cool = (gap > 0) ? gap - 1 : 0;
            end
            @(posedge clock);
            #1;
            if (cool > 0) begin
                in_valid = 1'b0;
                cool--;
            end else if (prod_en) begin
                in_valid = 1'b1;
                in_data  = word_val;
            end else begin
                in_valid = 1'b0;
            end
            if (stall_en) begin
                if (stall_left > 0) begin
                    avm_waitrequest = 1'b1;
                    stall_left--;
                end else if ($urandom_range(0, 2) == 0) begin
                    avm_waitrequest = 1'b1;
                    stall_left = $urandom_range(0, 4);
                end else begin
                    avm_waitrequest = 1'b0;
                end
            end else begin
                avm_waitrequest = 1'b0;
                stall_left = 0;
            end
        end
    end

    task automatic setup_transfer(input int n, input logic [31:0] base, input bit stall, input int g);
        int          rem;
        int          off;
        int          bc;
        burst_t      b;
        logic [31:0] d;
        prod_en = 1'b0;
        csr_write(3'd1, 32'(n));
        csr_write(3'd2, base);
        csr_read(3'd2, d);
        chk("dest_base_readback", d, base);
        stall_en = stall;
        gap      = g;
        cool     = 0;
        word_val = 32'd0;
        hs_cnt   = 0;
        beat_cnt = 0;
        exp_data_q.delete();
        burst_q.delete();
        rem = n;
        off = 0;
        while (rem > 0) begin
            bc     = (rem > MAXB) ? MAXB : rem;
            b.addr = base + 32'(4 * off);
            b.bc   = 8'(bc);
            burst_q.push_back(b);
            off += bc;
            rem -= bc;
        end
        prod_en = 1'b1;
    endtask

    task automatic finish_transfer(input int n, input logic [31:0] exp_ww, input logic [31:0] exp_status);
        logic [31:0] d;
        bit          seen;
        seen = 1'b0;
        d    = 32'd0;
        for (int i = 0; i < n * 60 + 200; i++) begin
            @(posedge clock);
            #3;
            csr_read(3'd0, d);
            if (d == 32'd2) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            chk("done_timeout", d, 32'd2);
        end
        repeat (10) @(posedge clock);
        #3;
        csr_read(3'd3, d);
        chk("words_written", d, exp_ww);
        csr_read(3'd0, d);
        chk("status_after", d, exp_status);
        chk("beats_accepted", 32'(beat_cnt), 32'(n));
        chk("inputs_accepted", 32'(hs_cnt), 32'(n));
        chk("bursts_outstanding", 32'(burst_q.size()), 32'd0);
        chk("data_outstanding", 32'(exp_data_q.size()), 32'd0);
        prod_en = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit %0t reached, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[6];
        logic [31:0] d;
        bit          found;

        vecs[0] = '{8,  32'h0100_0000, 1'b0, 0, 32'd8,  32'd2};
        vecs[1] = '{20, 32'h0000_1000, 1'b0, 0, 32'd20, 32'd2};
        vecs[2] = '{8,  32'h0000_2000, 1'b1, 0, 32'd8,  32'd2};
        vecs[3] = '{8,  32'h0000_3000, 1'b0, 4, 32'd8,  32'd2};
        vecs[4] = '{12, 32'hFFFF_FFF0, 1'b0, 0, 32'd12, 32'd2};
        vecs[5] = '{5,  32'h0000_7004, 1'b1, 2, 32'd5,  32'd2};

        // Reset state
        resetn = 1'b0;
        repeat (3) @(posedge clock);
        #3;
        chk("reset_avm_write", {31'd0, avm_write}, 32'd0);
        chk("reset_avm_address", avm_address, 32'd0);
        chk("reset_avm_burstcount", 32'(avm_burstcount), 32'd0);
        chk("reset_avm_writedata", avm_writedata, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
        resetn = 1'b1;
        @(posedge clock);
        #3;
        for (int a = 0; a < 4; a++) begin
            csr_read(3'(a), d);
            chk("reset_csr", d, 32'd0);
        end
        chipselect = 1'b1;
        address    = 3'd2;
        #1;
        chk("readdata_without_read", readdata, 32'd0);
        chipselect = 1'b0;
        mon_en = 1'b1;

        // Table-driven transfers
        for (int i = 0; i < 6; i++) begin
            setup_transfer(vecs[i].n, vecs[i].base, vecs[i].stall, vecs[i].gap);
            csr_write(3'd0, 32'd0);
            finish_transfer(vecs[i].n, vecs[i].exp_ww, vecs[i].exp_status);
        end

        // Second start and LENGTH write during an active 16-word transfer are ignored
        setup_transfer(16, 32'h0000_5000, 1'b1, 0);
        csr_write(3'd0, 32'd0);
        repeat (4) @(posedge clock);
        csr_write(3'd1, 32'd4);
        csr_write(3'd0, 32'd0);
        csr_read(3'd1, d);
        chk("length_write_while_busy", d, 32'd16);
        finish_transfer(16, 32'd16, 32'd2);

        // Reset for one cycle in the middle of a burst, after beat 3 of 8
        setup_transfer(8, 32'h0000_6000, 1'b0, 0);
        csr_write(3'd0, 32'd0);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clock);
            #3;
            if (beat_cnt >= 3) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            chk("beat3_timeout", 32'(beat_cnt), 32'd3);
        end
        mon_en = 1'b0;
        resetn = 1'b0;
        @(posedge clock);
        #1;
        chk("midreset_avm_write", {31'd0, avm_write}, 32'd0);
        chk("midreset_in_ready", {31'd0, in_ready}, 32'd0);
        csr_read(3'd0, d);
        chk("midreset_status", d, 32'd0);
        csr_read(3'd3, d);
        chk("midreset_words_written", d, 32'd0);
        resetn  = 1'b1;
        prod_en = 1'b0;
        repeat (3) @(posedge clock);
        #3;
        chk("after_reset_in_ready", {31'd0, in_ready}, 32'd0);
        exp_data_q.delete();
        burst_q.delete();
        beats_left = 0;
        prev_stall = 1'b0;
        beat_cnt   = 0;
        mon_en     = 1'b1;

        // Start with N=0: done next cycle, never any write
        csr_read(3'd0, d);
        chk("status_before_zero_start", d, 32'd0);
        csr_write(3'd1, 32'd0);
        csr_write(3'd0, 32'd0);
        csr_read(3'd0, d);
        chk("status_zero_length", d, 32'd2);
        repeat (12) @(posedge clock);
        #3;
        chk("zero_length_beats", 32'(beat_cnt), 32'd0);
        csr_read(3'd0, d);
        chk("status_zero_length_idle", d, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vec_burst_write_master.md
Name: vec_burst_write_master

Overview:
- Avalon-MM burst write master that streams a 32-bit result vector from the FPGA fabric into SDRAM at a CPU-programmed base address.
- It is the write-side counterpart of the dot-product read engine and reuses the same CSR map style: the slave CSR configures and starts it, and the master writes to SDRAM.
- An internal FIFO buffers producer data so that a burst starts only when all of its beats are already buffered.

Parameters:
- FIFO_DEPTH, 16, input FIFO entries (power of 2, ≥ MAX_BURST).
- MAX_BURST, 8, maximum beats per write burst (≤ 255).

Ports:
- clock  in  1  system clock
- resetn  in  1  synchronous active-low reset
- chipselect  in  1  CSR select
- read  in  1  CSR read strobe
- write  in  1  CSR write strobe
- address  in  3  CSR word offset
- writedata  in  32  CSR write data
- readdata  out  32  CSR read data
- in_valid  in  1  producer data valid
- in_data  in  32  producer data word
- in_ready  out  1  block accepts in_data this cycle
- avm_address  out  32  SDRAM byte address of burst
- avm_write  out  1  write request
- avm_writedata  out  32  write beat data
- avm_byteenable  out  4  always 4'b1111
- avm_burstcount  out  8  beats in current burst
- avm_waitrequest  in  1  slave stall

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous, active-low. At reset: state IDLE, FIFO empty, all counters 0, length/base registers 0, avm_write=0, avm_address=0, avm_burstcount=0, avm_writedata=0, in_ready=0.
- CSR map:
  - 0 CTRL/STATUS: a write starts a transfer. Read returns {30'b0, done, busy}.
  - 1 LENGTH N (words, R/W).
  - 2 DEST_BASE (byte address, word aligned, R/W).
  - 3 WORDS_WRITTEN (R).
- CSR rules:
  - readdata is combinational. It is 0 unless chipselect&read.
  - Writes to offsets 1 and 2 while busy are ignored.
- Start:
  - A start with busy=0 and N>0 loads: rem_in=N, rem_out=N, cur_addr=DEST_BASE, WORDS_WRITTEN=0. It also clears done and enters WAIT.
  - A start with N=0 sets done=1, stays IDLE, and asserts busy for 0 cycles.
  - A start while busy is ignored.
- Input side:
  - in_ready = busy & (rem_in≠0) & FIFO not full.
  - Each handshake (in_valid&in_ready) pushes in_data and decrements rem_in.
  - The block never accepts more than N words.
- FSM:
  - IDLE: busy=0. On a valid start, go to WAIT.
  - WAIT: compute blen=min(MAX_BURST, rem_out). When FIFO count ≥ blen, latch avm_address=cur_addr and avm_burstcount=blen, set beat counter=blen, assert avm_write, and go to BURST.
  - BURST:
    - avm_write stays 1. avm_writedata = FIFO head. avm_address and avm_burstcount are held constant for the whole burst.
    - A beat is accepted when avm_write & !avm_waitrequest. On acceptance: pop the FIFO, decrement the beat counter and rem_out, increment WORDS_WRITTEN.
    - On the last beat: deassert avm_write next cycle and set cur_addr += 4*blen.
    - After the last beat: if rem_out=0, go to DONE, otherwise go to WAIT.
    - While avm_waitrequest=1, all master outputs are held stable.
  - DONE: for one cycle, set done=1 and busy=0, then go to IDLE. done stays set until the next start.
- FIFO: a push and a pop in the same cycle leave the count unchanged. Pushing when full and popping when empty are impossible by construction. The verifier asserts both.
- Gating guarantee: avm_write never deasserts mid-burst for lack of data.
- Address arithmetic: 32-bit, wraps modulo 2^32 with no error flag.
- Mid-operation reset: a synchronous reset during BURST drops avm_write on the next edge. FIFO contents are discarded and all state returns to reset values.
- Latency: with FIFO already holding blen words, the first beat is presented 1 cycle after entering WAIT. With no stalls, a burst occupies blen cycles plus 1 cycle returning to WAIT/DONE.

Test Plan:
- N=8, base 0x0100_0000, producer streams 0..7 continuously, no waitrequest -> one burst: burstcount=8, address 0x0100_0000, writedata 0..7 in order; WORDS_WRITTEN=8; STATUS reads 0x2.
- N=20, MAX_BURST=8, base 0x0000_1000 -> three bursts: (0x1000, 8), (0x1020, 8), (0x1040, 4); data is contiguous 0..19.
- N=8, random avm_waitrequest stalls of 1–5 cycles -> address, burstcount and writedata stay stable while stalled; exactly 8 accepted beats; order preserved.
- Producer supplies 1 word every 4 cycles, N=8 -> avm_write stays low until FIFO holds 8 words, then 8 consecutive beats with no bubbles in avm_write.
- Start with N=0 -> no avm_write ever; STATUS=0x2 next cycle. A second start written during an active N=16 transfer is ignored: exactly 16 beats total.
- resetn low for 1 cycle mid-BURST (after beat 3 of 8) -> avm_write=0 next cycle; STATUS=0, WORDS_WRITTEN=0, in_ready=0.
